// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative signed multiply/divide engine for the four-function calculator.
// A one-cycle Start pulse captures two W-bit two's-complement operands and an
// op select. The engine then runs W iterations of a radix-2 Booth multiply or
// a restoring divide on magnitudes. It finishes with a sign-fix/overflow
// cycle and a one-cycle Done pulse.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-high reset, forces idle and clears outputs
//   Start     in   request pulse, accepted in the idle and done states
//   Op        in   0 = multiply, 1 = divide (quotient), sampled with Start
//   Abort     in   synchronous cancel, returns to idle, keeps Result/Overflow
//   OperandA  in   multiplicand / dividend
//   OperandB  in   multiplier / divisor
//   Busy      out  high from the cycle after acceptance until Done
//   Done      out  one-cycle completion pulse
//   Result    out  W-bit result, held until the next Done or Reset
//   Overflow  out  result not representable in W bits, or divide by zero

module muldiv_sequencer #(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic         Abort,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic         Overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    SIdle,
    SLoad,
    SMul,
    SDiv,
    SFix,
    SDone
  } state_t;

  state_t           stateQ, stateD;
  logic             opQ, opD;
  logic [W-1:0]     aQ, aD;
  logic [W-1:0]     bQ, bD;
  // Booth register: {P (W+1 bits), M (W bits), guard bit}
  logic [2*W+1:0]   prodQ, prodD;
  // Restoring divider: partial remainder and shifting dividend/quotient
  logic [W:0]       remQ, remD;
  logic [W-1:0]     quoQ, quoD;
  logic [CW-1:0]    cntQ, cntD;
  logic [W-1:0]     resultQ, resultD;
  logic             ovfQ, ovfD;

  logic [W-1:0]     absA, absB;
  logic [W:0]       aExt, pPart, boothSum;
  logic [2*W+1:0]   prodShift;
  logic [W:0]       remShift;
  logic [W+1:0]     trial;
  logic             mulInRange;
  logic             quoNeg;

  // Datapath helpers shared by the iteration and fix-up states.
  always_comb begin
    absA      = aQ[W-1] ? -aQ : aQ;
    absB      = bQ[W-1] ? -bQ : bQ;
    aExt      = {aQ[W-1], aQ};
    pPart     = prodQ[2*W+1:W+1];

    // {M[0], guard} selects add, subtract or hold of the multiplicand.
    case (prodQ[1:0])
      2'b01:   boothSum = pPart + aExt;
      2'b10:   boothSum = pPart - aExt;
      default: boothSum = pPart;
    endcase
    prodShift = {boothSum[W], boothSum, prodQ[W:1]};

    // Shift the next dividend bit into the remainder and trial-subtract.
    // The extra top bit of trial is its sign.
    remShift  = {remQ[W-1:0], quoQ[W-1]};
    trial     = {1'b0, remShift} - {2'b00, absB};

    // After W Booth steps the signed product sits in prodQ[2W+1:1]; it fits
    // in W bits when everything from product bit W-1 upward is a sign copy.
    mulInRange = (&prodQ[2*W+1:W]) | ~(|prodQ[2*W+1:W]);
    quoNeg     = aQ[W-1] ^ bQ[W-1];
  end

  // Next-state and register updates; Abort overrides every state.
  always_comb begin
    stateD  = stateQ;
    opD     = opQ;
    aD      = aQ;
    bD      = bQ;
    prodD   = prodQ;
    remD    = remQ;
    quoD    = quoQ;
    cntD    = cntQ;
    resultD = resultQ;
    ovfD    = ovfQ;

    if (Abort) begin
      stateD = SIdle;
    end else begin
      case (stateQ)
        SIdle, SDone: begin
          if (Start) begin
            stateD = SLoad;
            opD    = Op;
            aD     = OperandA;
            bD     = OperandB;
          end else begin
            stateD = SIdle;
          end
        end

        SLoad: begin
          prodD  = {{(W+1){1'b0}}, bQ, 1'b0};
          remD   = '0;
          quoD   = absA;
          cntD   = CW'(W);
          stateD = opQ ? SDiv : SMul;
        end

        SMul: begin
          prodD = prodShift;
          cntD  = cntQ - CW'(1);
          if (cntQ == CW'(1)) stateD = SFix;
        end

        SDiv: begin
          if (!trial[W+1]) begin
            remD = trial[W:0];
            quoD = {quoQ[W-2:0], 1'b1};
          end else begin
            remD = remShift;
            quoD = {quoQ[W-2:0], 1'b0};
          end
          cntD = cntQ - CW'(1);
          if (cntQ == CW'(1)) stateD = SFix;
        end

        SFix: begin
          if (!opQ) begin
            resultD = prodQ[W:1];
            ovfD    = ~mulInRange;
          end else if (bQ == '0) begin
            resultD = '0;
            ovfD    = 1'b1;
          end else begin
            // A positive quotient of 2^(W-1) only occurs for -2^(W-1) / -1.
            resultD = quoNeg ? -quoQ : quoQ;
            ovfD    = ~quoNeg & quoQ[W-1];
          end
          stateD = SDone;
        end

        default: stateD = SIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ  <= SIdle;
      opQ     <= 1'b0;
      aQ      <= '0;
      bQ      <= '0;
      prodQ   <= '0;
      remQ    <= '0;
      quoQ    <= '0;
      cntQ    <= '0;
      resultQ <= '0;
      ovfQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      opQ     <= opD;
      aQ      <= aD;
      bQ      <= bD;
      prodQ   <= prodD;
      remQ    <= remD;
      quoQ    <= quoD;
      cntQ    <= cntD;
      resultQ <= resultD;
      ovfQ    <= ovfD;
    end
  end

  // Busy deliberately excludes SLoad, so it covers the W iterations plus the
  // fix-up cycle. All outputs decode registered state only.
  assign Busy     = (stateQ == SMul) | (stateQ == SDiv) | (stateQ == SFix);
  assign Done     = (stateQ == SDone);
  assign Result   = resultQ;
  assign Overflow = ovfQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: scoreboard of expected results with
// latency, checked whenever the DUT pulses Done.

module tb_muldiv_sequencer;

  localparam int W = 11;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Op;
  logic         Abort;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         Overflow;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         monE;
  int           cycleCount = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] lastRes;
  logic         lastOvf;

  muldiv_sequencer #(.W(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .Abort    (Abort),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .Overflow (Overflow)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 Clock = ~Clock;

  always @(posedge Clock) cycleCount <= cycleCount + 1;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model, built on integer arithmetic.
  task automatic modelOp(input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] r,
                         output logic o);
    int sa, sbv, p;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!op) begin
      p = sa * sbv;
      r = p[W-1:0];
      o = (p > 1023) || (p < -1024);
    end else if (sbv == 0) begin
      r = '0;
      o = 1'b1;
    end else begin
      p = sa / sbv;
      r = p[W-1:0];
      o = (p > 1023);
    end
  endtask

  // One-cycle Start pulse, driven from the current negedge.
  task automatic pulseStart(input logic op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    @(negedge Clock);
    Start    = 1'b0;
    OperandA = W'($urandom);
    OperandB = W'($urandom);
    Op       = 1'($urandom);
  endtask

  // Start an operation that must complete, and push its expectation.
  task automatic applyStimulus(input logic op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] expRes,
                               input logic expOvf);
    exp_t e;
    e.res = expRes;
    e.ovf = expOvf;
    e.cyc = cycleCount + W + 3;
    sb.push_back(e);
    lastRes = expRes;
    lastOvf = expOvf;
    pulseStart(op, a, b);
  endtask

  task automatic drainScoreboard();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge Clock);
    if (sb.size() != 0) begin
      checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge Clock);
  endtask

  task automatic waitForDone();
    int i;
    for (i = 0; i < 30 && !Done; i++) @(negedge Clock);
    if (!Done) checkOutput("doneTimeout", 32'(Done), 32'd1);
  endtask

  // Monitor: every Done pulse must match the head of the scoreboard.
  always begin
    @(posedge Clock);
    #1;
    if (Done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 32'(Done), 32'd0);
      end else begin
        monE = sb.pop_front();
        checkOutput("result", 32'(Result), 32'(monE.res));
        checkOutput("overflow", 32'(Overflow), 32'(monE.ovf));
        checkOutput("doneLatency", 32'(cycleCount), 32'(monE.cyc));
      end
    end
  end

  initial begin
    int busyCount;
    logic         rop;
    logic [W-1:0] ra, rb, rr;
    logic         ro;

    Reset    = 1'b1;
    Start    = 1'b0;
    Op       = 1'b0;
    Abort    = 1'b0;
    OperandA = '0;
    OperandB = '0;
    lastRes  = '0;
    lastOvf  = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetDone", 32'(Done), 32'd0);
    checkOutput("resetResult", 32'(Result), 32'd0);
    checkOutput("resetOverflow", 32'(Overflow), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // First multiply with Busy width measurement.
    applyStimulus(1'b0, W'(7), W'(-3), W'(-21), 1'b0);
    busyCount = 0;
    for (int i = 0; i < 16; i++) begin
      if (Busy) busyCount++;
      @(negedge Clock);
    end
    checkOutput("busyCycles", 32'(busyCount), 32'd12);
    drainScoreboard();

    // Multiply overflow and divide corner cases.
    applyStimulus(1'b0, W'(600), W'(4), W'(352), 1'b1);
    drainScoreboard();
    applyStimulus(1'b0, W'(-1024), W'(-1), W'(-1024), 1'b1);
    drainScoreboard();
    applyStimulus(1'b1, W'(-100), W'(7), W'(-14), 1'b0);
    drainScoreboard();
    applyStimulus(1'b1, W'(100), W'(-7), W'(-14), 1'b0);
    drainScoreboard();
    applyStimulus(1'b1, W'(6), W'(7), W'(0), 1'b0);
    drainScoreboard();
    applyStimulus(1'b1, W'(55), W'(0), W'(0), 1'b1);
    drainScoreboard();
    applyStimulus(1'b1, W'(-1024), W'(-1), W'(-1024), 1'b1);
    drainScoreboard();

    // Starts while busy must be ignored.
    applyStimulus(1'b0, W'(100), W'(9), W'(900), 1'b0);
    repeat (2) @(negedge Clock);
    pulseStart(1'b1, W'(-5), W'(3));
    repeat (3) @(negedge Clock);
    pulseStart(1'b0, W'(1), W'(1));
    drainScoreboard();
    repeat (14) @(negedge Clock);

    // Back-to-back: second Start lands in the Done cycle.
    applyStimulus(1'b1, W'(1000), W'(-3), W'(-333), 1'b0);
    waitForDone();
    applyStimulus(1'b0, W'(-31), W'(33), W'(-1023), 1'b0);
    drainScoreboard();

    // Abort mid-iteration: no Done, previous result held.
    pulseStart(1'b0, W'(50), W'(50));
    repeat (5) @(negedge Clock);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    checkOutput("abortBusy", 32'(Busy), 32'd0);
    checkOutput("abortDone", 32'(Done), 32'd0);
    checkOutput("abortResult", 32'(Result), 32'(lastRes));
    checkOutput("abortOverflow", 32'(Overflow), 32'(lastOvf));
    repeat (16) @(negedge Clock);

    // Asynchronous reset in the middle of an operation.
    pulseStart(1'b0, W'(3), W'(5));
    repeat (4) @(negedge Clock);
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(Busy), 32'd0);
    checkOutput("midResetResult", 32'(Result), 32'd0);
    checkOutput("midResetOverflow", 32'(Overflow), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    applyStimulus(1'b0, W'(-12), W'(85), W'(-1020), 1'b0);
    drainScoreboard();

    // Random operations against the model.
    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = W'($urandom);
      rb  = W'($urandom);
      modelOp(rop, ra, rb, rr, ro);
      applyStimulus(rop, ra, rb, rr, ro);
      drainScoreboard();
    end

    repeat (16) @(negedge Clock);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
